// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Bit positions within the receive status register
    localparam int unsigned ST_AVAIL = 0;
    localparam int unsigned ST_FE    = 1;
    localparam int unsigned ST_OR    = 2;
    localparam int unsigned ST_FULL  = 3;

    localparam int unsigned OS_RATE = 16;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: input synchroniser, x16 oversample divider and frame FSM.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK = 50000000,
    parameter int unsigned BAUD  = 115200
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int unsigned OS_DIV = CLOCK / (BAUD * OS_RATE);
    localparam int unsigned OW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

    rx_state_t     state, state_d;
    logic          rx_meta, rxs;
    logic [OW-1:0] os_cnt;
    logic          tick;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          brk;
    logic          start_mid, bit_mid;

    assign tick      = (os_cnt == OW'(OS_DIV - 1));
    assign start_mid = tick && (tick_cnt == 4'd7);
    assign bit_mid   = tick && (tick_cnt == 4'd15);

    // Two-flop synchroniser; presets to idle-high so reset never looks like a start bit
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    // Free-running divider, re-phased to the detected start edge
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            os_cnt <= '0;
        end else if ((state == IDLE) && (state_d == START)) begin
            os_cnt <= '0;
        end else if (tick) begin
            os_cnt <= '0;
        end else begin
            os_cnt <= os_cnt + OW'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (!rxs) state_d = START;
            START: if (start_mid) state_d = rxs ? IDLE : DATA;
            DATA:  if (bit_mid && (bit_cnt == 3'd7)) state_d = STOP;
            STOP: begin
                if (brk) begin
                    if (rxs) state_d = IDLE;
                end else if (bit_mid && rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: tick/bit counters, shifter and result strobes
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            brk        <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_byte    <= '0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    brk      <= 1'b0;
                end
                START: if (tick) tick_cnt <= start_mid ? 4'd0 : tick_cnt + 4'd1;
                DATA: begin
                    if (tick) tick_cnt <= tick_cnt + 4'd1;
                    if (bit_mid) begin
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                STOP: begin
                    if (tick && !brk) tick_cnt <= tick_cnt + 4'd1;
                    if (bit_mid && !brk) begin
                        if (rxs) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                            brk       <= 1'b1;
                        end
                    end
                end
                default: tick_cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_io.sv
// UART receiver on the Z80-style I/O bus: receive FIFO, sticky error flags and port decode.
module uart_rx_io
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK      = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter logic [7:0]  DATA_PORT  = 8'd9,
    parameter logic [7:0]  STAT_PORT  = 8'd11,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       uart_rx,
    input  logic [7:0] Address,
    input  logic       IORQ,
    input  logic       RD,
    output logic [7:0] Data_out,
    output logic       Data_oe,
    output logic       rx_irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic          byte_valid, frame_err;
    logic [7:0]    rx_byte;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full;
    logic          data_sel, stat_sel, data_sel_q, stat_sel_q, data_armed;
    logic          do_pop, push_ok, or_set, stat_clr;
    logic          fe, ovr;
    logic [7:0]    status;

    uart_rx_core #(
        .CLOCK (CLOCK),
        .BAUD  (BAUD)
    ) u_core (
        .clk        (clk),
        .nreset     (nreset),
        .uart_rx    (uart_rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign data_sel = IORQ & RD & (Address == DATA_PORT);
    assign stat_sel = IORQ & RD & (Address == STAT_PORT);
    assign Data_oe  = data_sel | stat_sel;

    // Side effects fire once per strobe, after it ends, so read data stays stable
    assign do_pop   = data_sel_q & ~data_sel & data_armed & ~empty;
    assign stat_clr = stat_sel_q & ~stat_sel;
    assign push_ok  = byte_valid & (~full | do_pop);
    assign or_set   = byte_valid & full & ~do_pop;

    always_comb begin
        status           = 8'h00;
        status[ST_AVAIL] = ~empty;
        status[ST_FE]    = fe;
        status[ST_OR]    = ovr;
        status[ST_FULL]  = full;
    end

    always_comb begin
        Data_out = 8'h00;
        if (data_sel) begin
            Data_out = empty ? 8'h00 : mem[rd_ptr];
        end else if (stat_sel) begin
            Data_out = status;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            data_sel_q <= 1'b0;
            stat_sel_q <= 1'b0;
            data_armed <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fe         <= 1'b0;
            ovr        <= 1'b0;
            rx_irq     <= 1'b0;
        end else begin
            data_sel_q <= data_sel;
            stat_sel_q <= stat_sel;
            // An empty-FIFO read returns zero and must not consume a byte that lands mid-strobe
            if (data_sel && !data_sel_q) data_armed <= ~empty;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (frame_err)     fe <= 1'b1;
            else if (stat_clr) fe <= 1'b0;
            if (or_set)        ovr <= 1'b1;
            else if (stat_clr) ovr <= 1'b0;
            rx_irq <= ~empty;
        end
    end

endmodule

// File: tb/tb_uart_rx_io.sv
// Randomised scoreboard bench for uart_rx_io against a queue-based behavioural model.
module tb_uart_rx_io;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BIT   = 16;
    localparam logic [7:0]  DPORT = 8'd9;
    localparam logic [7:0]  SPORT = 8'd11;

    logic       clk = 1'b0;
    logic       nreset, uart_rx, IORQ, RD;
    logic [7:0] Address, Data_out;
    logic       Data_oe, rx_irq;

    always #5 clk = ~clk;

    uart_rx_io #(
        .CLOCK      (1600),
        .BAUD       (100),
        .DATA_PORT  (DPORT),
        .STAT_PORT  (SPORT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .uart_rx  (uart_rx),
        .Address  (Address),
        .IORQ     (IORQ),
        .RD       (RD),
        .Data_out (Data_out),
        .Data_oe  (Data_oe),
        .rx_irq   (rx_irq)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_fifo[$];
    bit         m_fe = 1'b0;
    bit         m_or = 1'b0;
    logic       oe_prev = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle of a selected read must show the expected value
    always @(negedge clk) begin
        if (Data_oe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %02h expected no access", Data_out);
            end else begin
                check("bus_read", Data_out, exp_q[0]);
            end
        end else if (oe_prev && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
        oe_prev <= Data_oe;
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good);
        uart_rx = 1'b0;
        wclk(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wclk(BIT);
        end
        if (good) begin
            uart_rx = 1'b1;
            wclk(2 * BIT);
            if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
            else m_or = 1'b1;
        end else begin
            uart_rx = 1'b0;
            wclk(2 * BIT);
            uart_rx = 1'b1;
            wclk(2 * BIT);
            m_fe = 1'b1;
        end
    endtask

    task automatic bus_read(input logic [7:0] addr, input int len);
        logic [7:0] e;
        if (addr == DPORT) begin
            e = 8'h00;
            if (m_fifo.size() > 0) e = m_fifo.pop_front();
        end else begin
            e = {4'b0000, m_fifo.size() == DEPTH, m_or, m_fe, m_fifo.size() != 0};
            m_fe = 1'b0;
            m_or = 1'b0;
        end
        exp_q.push_back(e);
        Address = addr;
        IORQ    = 1'b1;
        RD      = 1'b1;
        wclk(len);
        IORQ    = 1'b0;
        RD      = 1'b0;
        Address = 8'h00;
        wclk(3);
    endtask

    task automatic check_irq(input string name);
        check(name, {7'b0, rx_irq}, {7'b0, m_fifo.size() != 0});
    endtask

    initial begin
        nreset  = 1'b0;
        uart_rx = 1'b1;
        IORQ    = 1'b0;
        RD      = 1'b0;
        Address = 8'h00;
        wclk(3);
        check("reset_data_out", Data_out, 8'h00);
        check("reset_data_oe", {7'b0, Data_oe}, 8'h00);
        check("reset_irq", {7'b0, rx_irq}, 8'h00);
        nreset = 1'b1;
        wclk(4);

        // Basic reception
        send_frame(8'hA5, 1'b1);
        check_irq("irq_after_rx");
        bus_read(SPORT, 1);
        bus_read(DPORT, 1);
        bus_read(SPORT, 1);
        check_irq("irq_after_pop");

        // Non-matching address / missing RD must not drive the bus
        Address = 8'd10; IORQ = 1'b1; RD = 1'b1;
        wclk(1);
        check("other_port_oe", {7'b0, Data_oe}, 8'h00);
        check("other_port_data", Data_out, 8'h00);
        Address = DPORT; RD = 1'b0;
        wclk(1);
        check("no_rd_oe", {7'b0, Data_oe}, 8'h00);
        IORQ = 1'b0; Address = 8'h00;
        wclk(2);

        // Short glitch is a false start
        uart_rx = 1'b0;
        wclk(3);
        uart_rx = 1'b1;
        wclk(40);
        bus_read(SPORT, 1);
        check_irq("irq_after_glitch");

        // Framing error, flag cleared by the read
        send_frame(8'h3C, 1'b0);
        bus_read(SPORT, 1);
        check_irq("irq_after_fe");
        bus_read(SPORT, 1);

        // Overrun
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        bus_read(SPORT, 1);
        for (int i = 0; i < 5; i++) bus_read(DPORT, 1);
        bus_read(SPORT, 1);

        // Two-cycle strobe pops a single byte
        send_frame(8'($urandom), 1'b1);
        send_frame(8'($urandom), 1'b1);
        bus_read(DPORT, 2);
        bus_read(DPORT, 1);
        bus_read(SPORT, 1);

        // Reset during bit 4 of a frame with a byte already buffered
        send_frame(8'h11, 1'b1);
        uart_rx = 1'b0;
        wclk(BIT);
        for (int i = 0; i < 4; i++) begin
            uart_rx = i[0];
            wclk(BIT);
        end
        uart_rx = 1'b1;
        wclk(8);
        nreset = 1'b0;
        m_fifo.delete();
        m_fe = 1'b0;
        m_or = 1'b0;
        wclk(3);
        nreset  = 1'b1;
        uart_rx = 1'b1;
        wclk(40);
        check_irq("irq_after_reset");
        send_frame(8'h7E, 1'b1);
        bus_read(SPORT, 1);
        bus_read(DPORT, 1);
        bus_read(SPORT, 1);

        // Random mix of frames and reads
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    send_frame(8'($urandom), $urandom_range(0, 7) != 0);
                2:       bus_read(DPORT, $urandom_range(1, 3));
                default: bus_read(SPORT, $urandom_range(1, 3));
            endcase
            check_irq("irq_random");
        end
        while (m_fifo.size() > 0) bus_read(DPORT, 1);
        bus_read(SPORT, 1);

        wclk(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
